count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_seq_checker.sv | 109 ++++++++++
 tb/tb_count_seq_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Watches a free-running 3-bit counter presented as {a,b,c} and reports lock,
// sticky sequence errors and a saturating count of correct 7->0 wraps.
module count_seq_checker #(
    parameter int LOCK_N = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    input  logic              en,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [2:0]        cur_val
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED, ERROR} state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

    state_t            state_q, state_d;
    logic [2:0]        prev_q, prev_d;
    logic [3:0]        goodCnt_q, goodCnt_d;
    logic [WRAP_W-1:0] wrapCnt_q, wrapCnt_d;
    logic              locked_q, err_q;

    logic [2:0] v;
    logic [3:0] goodInc;
    logic       stepOk;
    logic       isWrap;

    assign v       = {a, b, c};
    assign goodInc = goodCnt_q + 4'd1;
    assign stepOk  = (v == 3'(prev_q + 3'd1));
    assign isWrap  = (prev_q == 3'd7) && (v == 3'd0);

    // prev and cur_val always load together, so one register serves both.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        goodCnt_d = goodCnt_q;
        wrapCnt_d = wrapCnt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    prev_d    = v;
                    goodCnt_d = 4'd0;
                    state_d   = TRACK;
                end
            end
            TRACK, LOCKED: begin
                if (en) begin
                    prev_d = v;
                    if (stepOk) begin
                        if (state_q == TRACK) begin
                            goodCnt_d = goodInc;
                            if (goodInc == LOCK_CNT) begin
                                state_d = LOCKED;
                            end
                        end
                        if (isWrap && (wrapCnt_q != {WRAP_W{1'b1}})) begin
                            wrapCnt_d = wrapCnt_q + WRAP_W'(1);
                        end
                    end else begin
                        state_d   = ERROR;
                        goodCnt_d = 4'd0;
                    end
                end
            end
            ERROR: begin
                // Clearing takes priority and discards any sample on the same edge.
                if (clr_err) begin
                    state_d   = IDLE;
                    goodCnt_d = 4'd0;
                end else if (en) begin
                    prev_d = v;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= 3'd0;
            goodCnt_q <= 4'd0;
            wrapCnt_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            goodCnt_q <= goodCnt_d;
            wrapCnt_q <= wrapCnt_d;
            locked_q  <= (state_d == LOCKED);
            err_q     <= (state_d == ERROR);
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign wrap_cnt = wrapCnt_q;
    assign cur_val  = prev_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus a randomized run, all
// checked against a behavioural model; two instances cover WRAP_W=8 and WRAP_W=4.
module tb_count_seq_checker;

    localparam int LOCK_N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked8, err8, locked4, err4;
    logic [7:0] wrap8;
    logic [3:0] wrap4;
    logic [2:0] cur8, cur4;

    int checks = 0;
    int failures = 0;

    // Behavioural model: a "seen first sample" flag, an error flag, a lock flag
    // and a run length of correct steps.
    bit mSeen, mErr, mLock;
    int mStreak, mPrev, mWrap8, mWrap4;

    always #5 clk = ~clk;

    count_seq_checker #(.LOCK_N(LOCK_N), .WRAP_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en), .clr_err(clr_err),
        .locked(locked8), .err(err8), .wrap_cnt(wrap8), .cur_val(cur8)
    );

    count_seq_checker #(.LOCK_N(LOCK_N), .WRAP_W(4)) dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en), .clr_err(clr_err),
        .locked(locked4), .err(err4), .wrap_cnt(wrap4), .cur_val(cur4)
    );

    task automatic modelStep(input bit r, input bit e, input bit cl, input int v);
        if (r) begin
            mSeen = 0; mErr = 0; mLock = 0; mStreak = 0;
            mPrev = 0; mWrap8 = 0; mWrap4 = 0;
        end else if (mErr) begin
            if (cl) begin
                mErr = 0; mSeen = 0; mStreak = 0;
            end else if (e) begin
                mPrev = v;
            end
        end else if (e) begin
            if (!mSeen) begin
                mSeen = 1; mStreak = 0;
            end else if (v == (mPrev + 1) % 8) begin
                if (!mLock) begin
                    mStreak++;
                    if (mStreak == LOCK_N) mLock = 1;
                end
                if (mPrev == 7 && v == 0) begin
                    if (mWrap8 < 255) mWrap8++;
                    if (mWrap4 < 15) mWrap4++;
                end
            end else begin
                mErr = 1; mLock = 0; mStreak = 0;
            end
            mPrev = v;
        end
    endtask

    // Drives one clock worth of inputs, advances the model, samples 1 time unit after the edge.
    task automatic applyStimulus(input bit r, input bit e, input bit cl, input int v);
        logic [2:0] vv;
        vv = 3'(v);
        rst = r; en = e; clr_err = cl;
        {a, b, c} = vv;
        @(posedge clk);
        modelStep(r, e, cl, v);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 5);
        checks++;
        if ({locked8, err8, wrap8, cur8} !== 14'd0) begin
            failures++;
            $display("[TB] FAIL reset8 got locked=%0b err=%0b wrap=%0d cur=%0d want all 0", locked8, err8, wrap8, cur8);
        end
        checks++;
        if ({locked4, err4, wrap4, cur4} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset4 got locked=%0b err=%0b wrap=%0d cur=%0d want all 0", locked4, err4, wrap4, cur4);
        end
    endtask

    task automatic test_lock();
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, i);
        checks++;
        if (locked8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lock_early got %0b want 0", locked8);
        end
        applyStimulus(0, 1, 0, 0);
        checks++;
        if ({locked8, err8, wrap8, cur8} !== {1'b1, 1'b0, 8'd1, 3'd0}) begin
            failures++;
            $display("[TB] FAIL lock8 got locked=%0b err=%0b wrap=%0d cur=%0d want 1 0 1 0", locked8, err8, wrap8, cur8);
        end
        checks++;
        if ({locked4, wrap4} !== {1'b1, 4'd1}) begin
            failures++;
            $display("[TB] FAIL lock4 got locked=%0b wrap=%0d want 1 1", locked4, wrap4);
        end
    endtask

    task automatic test_error();
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 1, 0, 5);
        checks++;
        if ({err8, locked8, cur8} !== {1'b1, 1'b0, 3'd5}) begin
            failures++;
            $display("[TB] FAIL err_set got err=%0b locked=%0b cur=%0d want 1 0 5", err8, locked8, cur8);
        end
        applyStimulus(0, 1, 0, 6);
        applyStimulus(0, 1, 0, 7);
        checks++;
        if ({err8, wrap8, cur8} !== {1'b1, 8'd1, 3'd7}) begin
            failures++;
            $display("[TB] FAIL err_hold got err=%0b wrap=%0d cur=%0d want 1 1 7", err8, wrap8, cur8);
        end
        applyStimulus(0, 0, 1, 0);
        checks++;
        if ({err8, locked8, cur8} !== {1'b0, 1'b0, 3'd7}) begin
            failures++;
            $display("[TB] FAIL err_clr got err=%0b locked=%0b cur=%0d want 0 0 7", err8, locked8, cur8);
        end
    endtask

    task automatic test_gap();
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 1, 0, 3);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, int'($urandom_range(0, 7)));
        applyStimulus(0, 1, 0, 4);
        checks++;
        if ({err8, locked8, cur8} !== {1'b0, 1'b0, 3'd4}) begin
            failures++;
            $display("[TB] FAIL gap got err=%0b locked=%0b cur=%0d want 0 0 4", err8, locked8, cur8);
        end
        // Two steps are banked; six more should lock exactly on the sixth.
        for (int i = 5; i < 10; i++) applyStimulus(0, 1, 0, i % 8);
        checks++;
        if (locked8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gap_cnt_early got locked=%0b want 0", locked8);
        end
        applyStimulus(0, 1, 0, 2);
        checks++;
        if ({locked8, wrap8} !== {1'b1, 8'd2}) begin
            failures++;
            $display("[TB] FAIL gap_cnt got locked=%0b wrap=%0d want 1 2", locked8, wrap8);
        end
    endtask

    task automatic test_clr_with_en();
        applyStimulus(0, 1, 0, 2);
        checks++;
        if ({err8, locked8} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL repeat_err got err=%0b locked=%0b want 1 0", err8, locked8);
        end
        applyStimulus(0, 1, 1, 4);
        checks++;
        if ({err8, cur8} !== {1'b0, 3'd2}) begin
            failures++;
            $display("[TB] FAIL clr_en got err=%0b cur=%0d want 0 2", err8, cur8);
        end
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 2);
        checks++;
        if ({err8, cur8} !== {1'b0, 3'd2}) begin
            failures++;
            $display("[TB] FAIL clr_first got err=%0b cur=%0d want 0 2", err8, cur8);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, i);
        applyStimulus(1, 1, 0, 5);
        applyStimulus(0, 1, 0, 6);
        applyStimulus(0, 1, 0, 7);
        checks++;
        if ({err8, wrap8, cur8} !== {1'b0, 8'd0, 3'd7}) begin
            failures++;
            $display("[TB] FAIL rst_mid got err=%0b wrap=%0d cur=%0d want 0 0 7", err8, wrap8, cur8);
        end
    endtask

    task automatic test_wrap_sat();
        applyStimulus(1, 0, 0, 0);
        for (int s = 0; s < 64; s++)
            for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, i);
        checks++;
        if ({wrap4, wrap8, err4, locked4} !== {4'd15, 8'd63, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wrap_sat got wrap4=%0d wrap8=%0d err=%0b locked=%0b want 15 63 0 1", wrap4, wrap8, err4, locked4);
        end
        applyStimulus(0, 1, 0, 0);
        checks++;
        if ({wrap4, wrap8} !== {4'd15, 8'd64}) begin
            failures++;
            $display("[TB] FAIL wrap_sat_hold got wrap4=%0d wrap8=%0d want 15 64", wrap4, wrap8);
        end
    endtask

    task automatic test_random();
        int v;
        bit r, e, cl;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 75);
            cl = ($urandom_range(0, 99) < 10);
            v  = ($urandom_range(0, 99) < 85) ? (mPrev + 1) % 8 : int'($urandom_range(0, 7));
            applyStimulus(r, e, cl, v);
            checks++;
            if ({locked8, err8, wrap8, cur8} !== {mLock, mErr, 8'(mWrap8), 3'(mPrev)}) begin
                failures++;
                $display("[TB] FAIL rand8 n=%0d got locked=%0b err=%0b wrap=%0d cur=%0d want %0b %0b %0d %0d",
                         n, locked8, err8, wrap8, cur8, mLock, mErr, mWrap8, mPrev);
            end
            checks++;
            if ({locked4, err4, wrap4, cur4} !== {mLock, mErr, 4'(mWrap4), 3'(mPrev)}) begin
                failures++;
                $display("[TB] FAIL rand4 n=%0d got locked=%0b err=%0b wrap=%0d cur=%0d want %0b %0b %0d %0d",
                         n, locked4, err4, wrap4, cur4, mLock, mErr, mWrap4, mPrev);
            end
        end
    endtask

    initial begin
        modelStep(1, 0, 0, 0);
        test_reset();
        test_lock();
        test_error();
        test_gap();
        test_clr_with_en();
        test_reset_mid();
        test_wrap_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
